hazard_scoreboard: RTL and testbench

- Parametrised successor to the combinational decoder's hazard support.
- Tracks in-flight register writes across STAGES post-decode pipeline stages (E, M, W by default) using per-stage remaining-latency (Tnew) counters.
- From that state it generates the D-stage stall, the D-stage forward selects, and a multi-cycle MDU busy interlock.
- Sits beside the D stage. It consumes the decoder's rs/rt/grf_WA/grf_writeEn plus per-instruction Tuse/Tnew and MDU-class flags.

---
 rtl/hazard_scoreboard_if.sv | 35 +++
 rtl/hazard_scoreboard.sv | 74 +++++++
 tb/tb_hazard_scoreboard.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: D-stage decode fields in, stall/forward/MDU-busy out.
// master = decoder side (drives i_*), slave = scoreboard (drives o_*).
interface hazard_scoreboard_if #(
  parameter int AW   = 5,
  parameter int TW   = 2,
  parameter int SELW = 2
);
  logic            i_id_valid;
  logic [AW-1:0]   i_rs;
  logic [AW-1:0]   i_rt;
  logic [TW-1:0]   i_tuse_rs;
  logic [TW-1:0]   i_tuse_rt;
  logic            i_use_rs;
  logic            i_use_rt;
  logic            i_we;
  logic [AW-1:0]   i_wa;
  logic [TW-1:0]   i_tnew;
  logic            i_md;
  logic            i_md_div;
  logic            i_mdu_use;
  logic            o_stall;
  logic [SELW-1:0] o_fwd_rs_sel;
  logic [SELW-1:0] o_fwd_rt_sel;
  logic            o_mdu_busy;
  modport master (
    output i_id_valid, i_rs, i_rt, i_tuse_rs, i_tuse_rt, i_use_rs, i_use_rt,
           i_we, i_wa, i_tnew, i_md, i_md_div, i_mdu_use,
    input  o_stall, o_fwd_rs_sel, o_fwd_rt_sel, o_mdu_busy
  );
  modport slave (
    input  i_id_valid, i_rs, i_rt, i_tuse_rs, i_tuse_rt, i_use_rs, i_use_rt,
           i_we, i_wa, i_tnew, i_md, i_md_div, i_mdu_use,
    output o_stall, o_fwd_rs_sel, o_fwd_rt_sel, o_mdu_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Tnew/Tuse scoreboard producing D-stage stall, forward selects and MDU interlock.
// Ports: i_clk clock; i_reset_n sync active-low reset; bus (slave) carries the D-stage
// decode fields (rs/rt/Tuse/use, we/wa/Tnew, md class) and returns o_stall, o_fwd_rs_sel,
// o_fwd_rt_sel (0 = GRF, k = stage k) and o_mdu_busy.
module hazard_scoreboard #(
  parameter int STAGES  = 3,
  parameter int AW      = 5,
  parameter int TW      = 2,
  parameter int SELW    = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input logic                i_clk,
  input logic                i_reset_n,
  hazard_scoreboard_if.slave bus
);
  logic [STAGES:1] vwe;
  logic [AW-1:0]   wa [1:STAGES];
  logic [TW-1:0]   tn [1:STAGES];
  logic [5:0]      mdu_cnt;
  logic            rs_hit, rt_hit, issue;
  logic [SELW-1:0] rs_k, rt_k;
  logic [TW-1:0]   rs_tn, rt_tn;
  // scanning oldest to youngest lets the youngest match overwrite older ones
  always_comb begin
    rs_hit = 1'b0;
    rs_k   = '0;
    rs_tn  = '0;
    rt_hit = 1'b0;
    rt_k   = '0;
    rt_tn  = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (vwe[k] && wa[k] == bus.i_rs) begin
        rs_hit = 1'b1;
        rs_k   = SELW'(k);
        rs_tn  = tn[k];
      end
      if (vwe[k] && wa[k] == bus.i_rt) begin
        rt_hit = 1'b1;
        rt_k   = SELW'(k);
        rt_tn  = tn[k];
      end
    end
    rs_hit = rs_hit && bus.i_use_rs && bus.i_rs != '0;
    rt_hit = rt_hit && bus.i_use_rt && bus.i_rt != '0;
  end
  assign bus.o_stall = bus.i_id_valid && ((rs_hit && rs_tn > bus.i_tuse_rs) ||
                       (rt_hit && rt_tn > bus.i_tuse_rt) || (bus.i_mdu_use && mdu_cnt != '0));
  assign bus.o_fwd_rs_sel = (rs_hit && rs_tn == '0) ? rs_k : '0;
  assign bus.o_fwd_rt_sel = (rt_hit && rt_tn == '0) ? rt_k : '0;
  assign bus.o_mdu_busy   = mdu_cnt != '0;
  assign issue            = bus.i_id_valid && !bus.o_stall;
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      vwe     <= '0;
      mdu_cnt <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        wa[k] <= '0;
        tn[k] <= '0;
      end
    end else begin
      for (int k = 2; k <= STAGES; k++) begin
        vwe[k] <= vwe[k-1];
        wa[k]  <= wa[k-1];
        tn[k]  <= (tn[k-1] == '0) ? '0 : tn[k-1] - TW'(1);
      end
      vwe[1]  <= issue && bus.i_we && bus.i_wa != '0;
      wa[1]   <= issue ? bus.i_wa : '0;
      tn[1]   <= issue ? bus.i_tnew : '0;
      mdu_cnt <= (issue && bus.i_md) ? (bus.i_md_div ? 6'(DIV_LAT) : 6'(MUL_LAT)) :
                 (mdu_cnt != '0) ? mdu_cnt - 6'd1 : mdu_cnt;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus randomized traffic against an age-based reference model.
module tb_hazard_scoreboard;
  localparam int S = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  hazard_scoreboard_if #(.AW(5), .TW(2), .SELW(2)) bus ();
  hazard_scoreboard dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // Model: history of what entered E on each of the last S cycles; slot j is stage j+1.
  // Remaining latency of an entry is its issued Tnew minus its age, floored at 0.
  logic       hv  [0:S-1];
  logic [4:0] hwa [0:S-1];
  int         htn [0:S-1];
  int         md_age = 0;
  int         md_lat = 0;
  function automatic int youngest(input logic [4:0] r, input logic u);
    youngest = 0;
    if (u && r != 0)
      for (int k = S; k >= 1; k--)
        if (hv[k-1] && hwa[k-1] == r) youngest = k;
  endfunction
  function automatic int remain(input int k);
    remain = (k == 0) ? 0 : htn[k-1] - (k - 1);
    if (remain < 0) remain = 0;
  endfunction
  function automatic logic m_stall();
    int a, b;
    a = youngest(bus.i_rs, bus.i_use_rs);
    b = youngest(bus.i_rt, bus.i_use_rt);
    m_stall = bus.i_id_valid && ((a != 0 && remain(a) > int'(bus.i_tuse_rs)) ||
              (b != 0 && remain(b) > int'(bus.i_tuse_rt)) || (bus.i_mdu_use && md_age < md_lat));
  endfunction
  function automatic int m_sel(input logic [4:0] r, input logic u);
    int k;
    k = youngest(r, u);
    m_sel = (k != 0 && remain(k) == 0) ? k : 0;
  endfunction
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < S; k++) begin
        hv[k]  <= 1'b0;
        hwa[k] <= '0;
        htn[k] <= 0;
      end
      md_age <= 0;
      md_lat <= 0;
    end else begin
      for (int k = S - 1; k >= 1; k--) begin
        hv[k]  <= hv[k-1];
        hwa[k] <= hwa[k-1];
        htn[k] <= htn[k-1];
      end
      hv[0]  <= bus.i_id_valid && !m_stall() && bus.i_we && bus.i_wa != 0;
      hwa[0] <= bus.i_wa;
      htn[0] <= (bus.i_id_valid && !m_stall()) ? int'(bus.i_tnew) : 0;
      if (bus.i_id_valid && !m_stall() && bus.i_md) begin
        md_lat <= bus.i_md_div ? 10 : 5;
        md_age <= 0;
      end else begin
        md_age <= md_age + 1;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic nop();
    bus.i_id_valid = 1'b0; bus.i_rs = '0; bus.i_rt = '0; bus.i_tuse_rs = '0; bus.i_tuse_rt = '0;
    bus.i_use_rs = 1'b0; bus.i_use_rt = 1'b0; bus.i_we = 1'b0; bus.i_wa = '0; bus.i_tnew = '0;
    bus.i_md = 1'b0; bus.i_md_div = 1'b0; bus.i_mdu_use = 1'b0;
  endtask
  task automatic writer(input logic [4:0] a, input logic [1:0] t);
    nop();
    bus.i_id_valid = 1'b1; bus.i_we = 1'b1; bus.i_wa = a; bus.i_tnew = t;
  endtask
  task automatic reader(input logic [4:0] r, input logic [1:0] tu);
    nop();
    bus.i_id_valid = 1'b1; bus.i_rs = r; bus.i_use_rs = 1'b1; bus.i_tuse_rs = tu;
  endtask
  task automatic do_reset();
    nop();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    do_reset();
    reader(5'd1, 2'd0);
    bus.i_mdu_use = 1'b1;
    @(negedge clk);
    checks += 4;
    if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.o_stall); end
    if (bus.o_fwd_rs_sel !== 2'd0) begin failures++; $display("FAIL reset_sel_rs got=%0d exp=0", bus.o_fwd_rs_sel); end
    if (bus.o_fwd_rt_sel !== 2'd0) begin failures++; $display("FAIL reset_sel_rt got=%0d exp=0", bus.o_fwd_rt_sel); end
    if (bus.o_mdu_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.o_mdu_busy); end
  endtask
  task automatic test_load_use();
    do_reset();
    writer(5'd1, 2'd2);
    tick();
    reader(5'd1, 2'd1);
    bus.i_rt = 5'd3; bus.i_use_rt = 1'b1; bus.i_tuse_rt = 2'd1; bus.i_we = 1'b1; bus.i_wa = 5'd2; bus.i_tnew = 2'd1;
    @(negedge clk);
    checks += 2;
    if (bus.o_stall !== 1'b1) begin failures++; $display("FAIL loaduse_stall1 got=%b exp=1", bus.o_stall); end
    if (bus.o_fwd_rs_sel !== 2'd0) begin failures++; $display("FAIL loaduse_sel1 got=%0d exp=0", bus.o_fwd_rs_sel); end
    tick();
    @(negedge clk);
    checks += 2;
    if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL loaduse_stall2 got=%b exp=0", bus.o_stall); end
    if (bus.o_fwd_rs_sel !== 2'd0) begin failures++; $display("FAIL loaduse_sel2 got=%0d exp=0", bus.o_fwd_rs_sel); end
    tick();
    reader(5'd1, 2'd0);
    @(negedge clk);
    checks += 2;
    if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL loaduse_stall3 got=%b exp=0", bus.o_stall); end
    if (bus.o_fwd_rs_sel !== 2'd3) begin failures++; $display("FAIL loaduse_sel_w got=%0d exp=3", bus.o_fwd_rs_sel); end
  endtask
  task automatic test_branch();
    do_reset();
    writer(5'd4, 2'd1);
    tick();
    reader(5'd4, 2'd0);
    bus.i_use_rt = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_stall !== 1'b1) begin failures++; $display("FAIL branch_stall got=%b exp=1", bus.o_stall); end
    tick();
    @(negedge clk);
    checks += 3;
    if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL branch_release got=%b exp=0", bus.o_stall); end
    if (bus.o_fwd_rs_sel !== 2'd2) begin failures++; $display("FAIL branch_sel_rs got=%0d exp=2", bus.o_fwd_rs_sel); end
    if (bus.o_fwd_rt_sel !== 2'd0) begin failures++; $display("FAIL branch_sel_rt0 got=%0d exp=0", bus.o_fwd_rt_sel); end
    do_reset();
    writer(5'd4, 2'd1);
    tick();
    reader(5'd4, 2'd0);
    bus.i_use_rs = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL branch_nouse got=%b exp=0", bus.o_stall); end
  endtask
  task automatic test_youngest();
    do_reset();
    writer(5'd5, 2'd1);
    tick();
    writer(5'd5, 2'd1);
    tick();
    reader(5'd5, 2'd1);
    @(negedge clk);
    checks += 2;
    if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL youngest_stall got=%b exp=0", bus.o_stall); end
    if (bus.o_fwd_rs_sel !== 2'd0) begin failures++; $display("FAIL youngest_sel got=%0d exp=0", bus.o_fwd_rs_sel); end
  endtask
  task automatic test_mdu(input logic div, input int lat);
    int n;
    do_reset();
    nop();
    bus.i_id_valid = 1'b1; bus.i_md = 1'b1; bus.i_md_div = div; bus.i_mdu_use = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_mdu_busy !== 1'b0) begin failures++; $display("FAIL mdu_idle got=%b exp=0", bus.o_mdu_busy); end
    tick();
    writer(5'd8, 2'd1);
    bus.i_mdu_use = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_mdu_busy !== 1'b1) begin failures++; $display("FAIL mdu_busy got=%b exp=1", bus.o_mdu_busy); end
    n = 0;
    while (bus.o_stall === 1'b1 && n < 30) begin
      n++;
      tick();
      @(negedge clk);
    end
    checks += 2;
    if (n != lat) begin failures++; $display("FAIL mdu_stall_cycles div=%b got=%0d exp=%0d", div, n, lat); end
    if (bus.o_mdu_busy !== 1'b0) begin failures++; $display("FAIL mdu_released got=%b exp=0", bus.o_mdu_busy); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    nop();
    bus.i_id_valid = 1'b1; bus.i_md = 1'b1; bus.i_md_div = 1'b1; bus.i_mdu_use = 1'b1;
    tick();
    nop();
    tick();
    tick();
    writer(5'd1, 2'd2);
    tick();
    reader(5'd1, 2'd1);
    bus.i_mdu_use = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_stall !== 1'b1) begin failures++; $display("FAIL midreset_pre got=%b exp=1", bus.o_stall); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks += 4;
    if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL midreset_stall got=%b exp=0", bus.o_stall); end
    if (bus.o_fwd_rs_sel !== 2'd0) begin failures++; $display("FAIL midreset_sel_rs got=%0d exp=0", bus.o_fwd_rs_sel); end
    if (bus.o_fwd_rt_sel !== 2'd0) begin failures++; $display("FAIL midreset_sel_rt got=%0d exp=0", bus.o_fwd_rt_sel); end
    if (bus.o_mdu_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", bus.o_mdu_busy); end
  endtask
  task automatic test_zero();
    do_reset();
    writer(5'd0, 2'd2);
    tick();
    reader(5'd0, 2'd0);
    bus.i_use_rt = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL zero_stall got=%b exp=0", bus.o_stall); end
    if (bus.o_fwd_rs_sel !== 2'd0) begin failures++; $display("FAIL zero_sel got=%0d exp=0", bus.o_fwd_rs_sel); end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      bus.i_id_valid = ($urandom_range(0, 7) != 0);
      bus.i_rs = 5'($urandom_range(0, 3));
      bus.i_rt = 5'($urandom_range(0, 3));
      bus.i_tuse_rs = 2'($urandom_range(0, 3));
      bus.i_tuse_rt = 2'($urandom_range(0, 3));
      bus.i_use_rs = 1'($urandom_range(0, 1));
      bus.i_use_rt = 1'($urandom_range(0, 1));
      bus.i_we = 1'($urandom_range(0, 1));
      bus.i_wa = 5'($urandom_range(0, 3));
      bus.i_tnew = 2'($urandom_range(0, 3));
      bus.i_md = ($urandom_range(0, 15) == 0);
      bus.i_md_div = 1'($urandom_range(0, 1));
      bus.i_mdu_use = bus.i_md || ($urandom_range(0, 5) == 0);
      @(negedge clk);
      checks += 4;
      if (bus.o_stall !== m_stall()) begin failures++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, bus.o_stall, m_stall()); end
      if (int'(bus.o_fwd_rs_sel) != m_sel(bus.i_rs, bus.i_use_rs)) begin failures++; $display("FAIL rnd_sel_rs i=%0d got=%0d exp=%0d", i, bus.o_fwd_rs_sel, m_sel(bus.i_rs, bus.i_use_rs)); end
      if (int'(bus.o_fwd_rt_sel) != m_sel(bus.i_rt, bus.i_use_rt)) begin failures++; $display("FAIL rnd_sel_rt i=%0d got=%0d exp=%0d", i, bus.o_fwd_rt_sel, m_sel(bus.i_rt, bus.i_use_rt)); end
      if (bus.o_mdu_busy !== (md_age < md_lat)) begin failures++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, bus.o_mdu_busy, md_age < md_lat); end
      tick();
    end
    rst_n = 1'b1;
  endtask
  initial begin
    nop();
    test_reset();
    test_load_use();
    test_branch();
    test_youngest();
    test_mdu(1'b1, 10);
    test_mdu(1'b0, 5);
    test_reset_mid();
    test_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
